// File: rtl/upe_sumsq_seq.sv
// rtl/upe_sumsq_seq.sv - sum-of-squares sequencer around an external 16x16 multiplier
// Each (a,b) pair takes two multiplier passes: t = sat16((a*b)>>PROD_SHIFT), then t*t into the accumulator.
module upe_sumsq_seq #(
    parameter int PROD_SHIFT = 8,
    parameter int ACC_W      = 40,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_last,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [31:0]      mul_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {S_IDLE, S_MUL1, S_MUL2, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_armed;
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic               r_last;
    logic [15:0]        r_t;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [31:0]        w_shifted;
    logic [15:0]        w_term;
    logic [ACC_W:0]     w_sum;

    assign w_shifted = mul_out >> PROD_SHIFT;
    assign w_term    = (|w_shifted[31:16]) ? 16'hFFFF : w_shifted[15:0];
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 31){1'b0}}, mul_out};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid && in_ready) w_next = S_MUL1;
            S_MUL1: w_next = S_MUL2;
            S_MUL2: w_next = r_last ? S_DONE : S_IDLE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_a     = 16'h0000;
        mul_b     = 16'h0000;
        case (r_state)
            S_IDLE: in_ready = r_armed;
            S_MUL1: begin
                mul_a = r_a;
                mul_b = r_b;
            end
            S_MUL2: begin
                mul_a = r_t;
                mul_b = r_t;
            end
            S_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_a    <= '0;
            r_b    <= '0;
            r_last <= 1'b0;
            r_t    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_last <= in_last;
                    end
                end
                S_MUL1: r_t <= w_term;
                S_MUL2: begin
                    if (w_sum[ACC_W]) begin
                        r_acc <= '1;
                        r_ovf <= 1'b1;
                    end else begin
                        r_acc <= w_sum[ACC_W-1:0];
                    end
                    if (!(&r_cnt)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum   = r_acc;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

endmodule
